// File: rtl/mult_div_unit.sv
// mult_div_unit: WIDTH-parametrised radix-2 multiply / restoring divide unit.
// Revision 1.0 - initial release.
`default_nettype none

module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic                         Clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [1:0]                   op,
  input  logic [WIDTH-1:0]             lhs,
  input  logic [WIDTH-1:0]             rhs,
  output logic                         busy,
  output logic                         done,
  output logic [WIDTH-1:0]             hi,
  output logic [WIDTH-1:0]             lo,
  output logic                         div_zero,
  output logic [$clog2(WIDTH+1)-1:0]   counter
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             dz_op_q, dz_op_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;

  // op[0]=0 selects the signed variants; operands enter the datapath as magnitudes.
  logic             lhs_neg, rhs_neg;
  logic [WIDTH-1:0] lhs_mag, rhs_mag;
  assign lhs_neg = ~op[0] & lhs[WIDTH-1];
  assign rhs_neg = ~op[0] & rhs[WIDTH-1];
  assign lhs_mag = lhs_neg ? -lhs : lhs;
  assign rhs_mag = rhs_neg ? -rhs : rhs;

  // Shift-add step: multiplier sits in the low half and is consumed from bit 0.
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_next;
  assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring step: partial remainder in the upper half, quotient bits shift in at bit 0.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_diff, rem_new;
  logic             q_bit;
  logic [W2-1:0]    div_next;
  assign rem_sh   = acc_q[W2-1:WIDTH-1];
  assign q_bit    = (rem_sh >= {1'b0, opnd_q});
  assign rem_diff = rem_sh[WIDTH-1:0] - opnd_q;
  assign rem_new  = q_bit ? rem_diff : rem_sh[WIDTH-1:0];
  assign div_next = {rem_new, acc_q[WIDTH-2:0], q_bit};

  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  assign prod_fix = neg_lo_q ? -acc_q : acc_q;
  // A zero divisor yields an all-ones quotient that must not be sign-corrected.
  assign quo_fix  = (neg_lo_q & ~dz_op_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_hi_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_op_q  <= 1'b0;
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_op_q  <= dz_op_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_op_d  = dz_op_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_div_d = op[1];
          neg_lo_d = lhs_neg ^ rhs_neg;
          neg_hi_d = op[1] & lhs_neg;
          dz_op_d  = op[1] & (rhs == '0);
          acc_d    = {{WIDTH{1'b0}}, (op[1] ? lhs_mag : rhs_mag)};
          opnd_d   = op[1] ? rhs_mag : lhs_mag;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[W2-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        dz_d    = dz_op_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;
  assign counter  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed table, corner sequences, random vs. arithmetic model.
`default_nettype none

module tb_mult_div_unit;

  localparam int W = 32;

  logic          Clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  lhs, rhs;
  logic          busy, done, div_zero;
  logic [W-1:0]  hi, lo;
  logic [5:0]    counter;

  logic          start8;
  logic [1:0]    op8;
  logic [7:0]    lhs8, rhs8, hi8, lo8;
  logic          busy8, done8, dz8;
  logic [3:0]    counter8;

  always #5 Clk = ~Clk;

  mult_div_unit #(.WIDTH(W)) u_dut (
    .Clk(Clk), .reset_n(reset_n), .start(start), .op(op), .lhs(lhs), .rhs(rhs),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero), .counter(counter)
  );

  mult_div_unit #(.WIDTH(8)) u_dut8 (
    .Clk(Clk), .reset_n(reset_n), .start(start8), .op(op8), .lhs(lhs8), .rhs(rhs8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_zero(dz8), .counter(counter8)
  );

  typedef struct {
    logic [1:0]   op;
    logic [31:0]  a, b;
    logic [31:0]  hi, lo;
    logic         dz;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] h, output logic [31:0] l, output logic dz);
    longint sa, sb, q, r;
    logic [63:0] p;
    dz = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (o)
      2'd0: p = sa * sb;
      2'd1: p = {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 32'd0) begin
          p  = {a, 32'hFFFF_FFFF};
          dz = 1'b1;
        end else if (o == 2'd2) begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end else begin
          p = {a % b, a / b};
        end
      end
    endcase
    h = p[63:32];
    l = p[31:0];
  endtask

  // Issues one operation; if disturb>0 a stray start with new operands is pulsed mid-run.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input logic edz, input int disturb);
    int n, bad_busy, bad_cnt;
    @(negedge Clk);
    op = o; lhs = a; rhs = b; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0; op = 2'($urandom); lhs = $urandom; rhs = $urandom;
    n = 0; bad_busy = 0; bad_cnt = 0;
    while (!done && n < W + 10) begin
      if (!busy) bad_busy++;
      if (n < W && counter != 6'(n)) bad_cnt++;
      start = (disturb > 0 && n == disturb);
      @(posedge Clk); #1;
      n++;
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(n), 64'(W + 1));
    check({tag, " busy_during_run"}, 64'(bad_busy), 64'd0);
    check({tag, " counter_seq"}, 64'(bad_cnt), 64'd0);
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    check({tag, " hi"}, 64'(hi), 64'(eh));
    check({tag, " lo"}, 64'(lo), 64'(el));
    check({tag, " div_zero"}, 64'(div_zero), 64'(edz));
    @(posedge Clk); #1;
    check({tag, " done_pulse"}, 64'(done), 64'd0);
    check({tag, " hold"}, {hi, lo}, {eh, el});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      3: return 32'd1;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  vec_t tbl[9];

  initial begin
    logic [31:0] eh, el, a, b;
    logic        edz;
    logic [1:0]  o;
    int          n, seen_done;

    tbl[0] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    tbl[1] = '{2'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    tbl[2] = '{2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    tbl[3] = '{2'd3, 32'd7,         32'd2,         32'd1,         32'd3,         1'b0};
    tbl[4] = '{2'd3, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1};
    tbl[5] = '{2'd1, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0};
    tbl[6] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
    tbl[7] = '{2'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    tbl[8] = '{2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};

    reset_n = 1'b0; start = 1'b0; op = 2'd0; lhs = '0; rhs = '0;
    start8 = 1'b0; op8 = 2'd0; lhs8 = '0; rhs8 = '0;
    repeat (2) @(posedge Clk);
    #1;
    check("reset outputs", {31'd0, busy, done, div_zero, counter, hi[25:0]}, 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    @(negedge Clk);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++)
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].dz, 0);

    // Stray start mid-run must not disturb the in-flight multiply.
    model(2'd0, 32'hFFF1_2345, 32'h0000_0678, eh, el, edz);
    run_op("midrun_start", 2'd0, 32'hFFF1_2345, 32'h0000_0678, eh, el, edz, 5);

    // Narrow instance: signed MIN x MIN.
    @(negedge Clk);
    op8 = 2'd0; lhs8 = 8'h80; rhs8 = 8'h80; start8 = 1'b1;
    @(posedge Clk); #1;
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 20) begin
      @(posedge Clk); #1;
      n++;
    end
    check("w8 latency", 64'(n), 64'd9);
    check("w8 result", {48'd0, hi8, lo8}, 64'h4000);

    // Abort at counter=10 via reset.
    @(negedge Clk);
    op = 2'd1; lhs = 32'h1234_5678; rhs = 32'h9ABC_DEF0; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    n = 0;
    while (counter != 6'd10 && n < W + 5) begin
      @(posedge Clk); #1;
      n++;
    end
    check("abort reached counter 10", 64'(counter), 64'd10);
    reset_n = 1'b0;
    #1;
    check("abort state", {busy, done, div_zero, counter}, 64'd0);
    check("abort hilo", {hi, lo}, 64'd0);
    seen_done = 0;
    repeat (3) begin
      @(posedge Clk); #1;
      if (done) seen_done++;
    end
    check("abort no done", 64'(seen_done), 64'd0);
    @(negedge Clk);
    reset_n = 1'b1;
    model(2'd3, 32'd1000, 32'd7, eh, el, edz);
    run_op("post_reset", 2'd3, 32'd1000, 32'd7, eh, el, edz, 0);

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      model(o, a, b, eh, el, edz);
      run_op($sformatf("rand%0d op%0d 0x%0h 0x%0h", i, o, a, b), o, a, b, eh, el, edz, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mult_div_unit.md
# mult_div_unit

- Parametrised, multi-cycle integer multiply/divide unit for the MIPS datapath.
- Computes signed and unsigned multiply (2·WIDTH-bit product) and signed and unsigned divide (quotient and remainder) one bit per cycle.
- Results go to HI/LO output registers, with a start/busy/done handshake toward the control FSM.
- Replaces the fixed 32-bit multiply-only block; it adds width generality, sign handling, division, divide-by-zero reporting and a defined latency.

## Interface

Parameters:
- WIDTH, default 32: operand width, any value ≥ 4. Results are two WIDTH-bit words.

Ports:
- Clk, input, 1: rising-edge clock. This is the block's only clock.
- reset_n, input, 1: asynchronous, active-low reset.
- start, input, 1: request a new operation. Sampled only while busy=0.
- op, input, 2: operation select, sampled with start. 00 = MULT (signed), 01 = MULTU, 10 = DIV (signed), 11 = DIVU.
- lhs, input, WIDTH: multiplicand / dividend, sampled with start.
- rhs, input, WIDTH: multiplier / divisor, sampled with start.
- busy, output, 1: operation in progress.
- done, output, 1: one-cycle pulse when hi/lo/div_zero are updated.
- hi, output, WIDTH: product upper half, or remainder.
- lo, output, WIDTH: product lower half, or quotient.
- div_zero, output, 1: the last completed operation was a divide with rhs=0. Valid from done; held until the next done.
- counter, output, clog2(WIDTH+1): iteration index, 0 when idle.

## Operation

- Reset (reset_n=0) clears all outputs and internal state immediately: busy=0, done=0, hi=0, lo=0, div_zero=0, counter=0. The FSM goes to IDLE.
- FSM states: IDLE → RUN → FIX → IDLE.
- IDLE, start=1: latch op. For signed ops, latch |lhs| and |rhs| and record the result signs. Clear the accumulator. Set counter=0 and go to RUN.
  - Multiply result sign = lhs sign XOR rhs sign.
  - Quotient sign = lhs sign XOR rhs sign; remainder sign = lhs sign.
- RUN, multiply: one radix-2 shift-add step per cycle on the 2·WIDTH-bit accumulator. The LSB of the multiplier selects whether to add.
- RUN, divide: one restoring shift-subtract step per cycle. It produces one quotient bit; the remainder lives in the upper half.
- RUN: counter increments every cycle. When counter = WIDTH-1, go to FIX.
- FIX: negate the results whose sign flags are set (two's complement, modulo 2^WIDTH per word, or 2^(2·WIDTH) for the product). Write hi/lo, pulse done and return to IDLE.
- Multiply results: {hi,lo} = lhs × rhs, exact, in 2·WIDTH bits.
- Divide results: lo = quotient truncated toward zero; hi = remainder, with the sign of the dividend.
- Divide by zero (both DIV and DIVU): lo = all ones, hi = lhs unchanged, div_zero=1. Latency is unchanged.
- Signed overflow (DIV of MIN by -1): lo = MIN, hi = 0, div_zero=0. This falls out of the magnitude arithmetic with no special case.
- hi/lo hold their values between completions. Their only writers are FIX and reset.
- start while busy=1 is ignored. It is not queued, and operands/op changing mid-run have no effect.
- start in the same cycle as done (FIX) is ignored. It is accepted from the next cycle, when busy=0.

## Timing

- start is sampled at edge E0. busy=1 from E0 until edge E0+WIDTH+1.
- RUN occupies edges E0+1 … E0+WIDTH. FIX is evaluated at edge E0+WIDTH+1.
- At edge E0+WIDTH+1: hi, lo and div_zero update, done=1 for exactly one cycle, and busy=0.
- Total latency is WIDTH+1 cycles from the start edge to the result. The earliest next start is sampled at edge E0+WIDTH+2.
- Back-to-back throughput: one operation per WIDTH+2 cycles.
- reset_n falling mid-RUN or mid-FIX aborts the operation. No done pulse is produced and hi/lo = 0.
- On reset_n release, the first start is sampled at the first rising edge after release.
- counter reads 0 in IDLE, and k during the k-th RUN cycle (0-based).

## Test plan

- WIDTH=32, MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. done exactly 33 cycles after the start edge, with busy high throughout.
- WIDTH=32, MULT -3 × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - Then WIDTH=8, MULT 0x80 × 0x80 → hi=0x40, lo=0x00.
- WIDTH=32, DIV -7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU 7 / 2 → lo=3, hi=1.
- WIDTH=32, DIVU 5 / 0 → lo=0xFFFFFFFF, hi=5, div_zero=1. A following MULTU 2 × 3 → lo=6, hi=0, div_zero=0.
- WIDTH=32, DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0, div_zero=0.
- Robustness:
  - Pulse start with new operands during RUN → ignored; the original result is unchanged.
  - Drive reset_n=0 at counter=10 → busy=0, hi=lo=0, no done.
  - A fresh start after release completes normally.
